// File: rtl/vxe_txn_defs_pkg.sv
// Coded request-data layout shared between the request data coder and this buffer.
// A coded vector is {ben[7:0], data[63:0]}.
package vxe_txn_defs;

    localparam int VXE_TXNREQD_WIDTH    = 72;
    localparam int VXE_TXNREQD_DATA_LSB = 0;
    localparam int VXE_TXNREQD_DATA_MSB = 63;
    localparam int VXE_TXNREQD_BEN_LSB  = 64;
    localparam int VXE_TXNREQD_BEN_MSB  = 71;

    typedef logic [VXE_TXNREQD_WIDTH-1:0] txnreqd_vec_t;

    function automatic logic [63:0] txnreqd_data(input txnreqd_vec_t vec);
        return vec[VXE_TXNREQD_DATA_MSB:VXE_TXNREQD_DATA_LSB];
    endfunction

    function automatic logic [7:0] txnreqd_ben(input txnreqd_vec_t vec);
        return vec[VXE_TXNREQD_BEN_MSB:VXE_TXNREQD_BEN_LSB];
    endfunction

endpackage

// File: rtl/vxe_txnreqd_buf_fifo_ram.sv
// Storage array for the request-data buffer: synchronous write, asynchronous read.
// Storage is deliberately not reset; occupancy tracking keeps stale words invisible.
module vxe_txnreqd_fifo_ram
    import vxe_txn_defs::*;
#(
    parameter int DEPTH_POW2 = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_POW2-1:0] wr_addr,
    input  txnreqd_vec_t          wr_data,
    input  logic [DEPTH_POW2-1:0] rd_addr,
    output txnreqd_vec_t          rd_data
);

    localparam int DEPTH = 1 << DEPTH_POW2;

    txnreqd_vec_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vxe_txnreqd_buf.sv
// First-word-fall-through buffer between the request data coder and the memory
// master write-data path; splits the coded vector back into data and byte enables.
module vxe_txnreqd_buf
    import vxe_txn_defs::*;
#(
    parameter int DEPTH_POW2 = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [VXE_TXNREQD_WIDTH-1:0] i_req_vec_dat,
    input  logic                         i_vld,
    output logic                         o_rdy,
    output logic [63:0]                  o_data,
    output logic [7:0]                   o_ben,
    output logic                         o_vld,
    input  logic                         i_rdy,
    output logic [DEPTH_POW2:0]          o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    localparam int PTR_W = DEPTH_POW2;
    localparam int CNT_W = DEPTH_POW2 + 1;
    localparam int DEPTH = 1 << DEPTH_POW2;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    txnreqd_vec_t     head_vec;

    // Handshake: a word moves on a rising edge when valid && ready on that side.
    // o_rdy and o_vld come from registered occupancy (and rst) only, never from
    // i_vld or i_rdy, so a full buffer cannot accept in the cycle it is popped.
    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_empty = (count == '0);
    assign o_rdy   = !o_full && !rst;
    assign o_vld   = !o_empty;
    assign o_count = count;

    assign push = i_vld && o_rdy;
    assign pop  = o_vld && i_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    vxe_txnreqd_fifo_ram #(
        .DEPTH_POW2(DEPTH_POW2)
    ) u_ram (
        .clk    (clk),
        .wr_en  (push),
        .wr_addr(wr_ptr),
        .wr_data(i_req_vec_dat),
        .rd_addr(rd_ptr),
        .rd_data(head_vec)
    );

    assign o_data = txnreqd_data(head_vec);
    assign o_ben  = txnreqd_ben(head_vec);

endmodule
